// File: rtl/uart_rx_if.sv
// Consumer-side bus of the serial receiver: holding-register handshake plus status flags.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_data_read;
  logic                 i_err_clear;
  logic [DATA_BITS-1:0] o_data_byte;
  logic                 o_data_valid;
  logic                 o_busy;
  logic                 o_frame_error;
  logic                 o_overrun;

  modport slave (
    input  i_data_read,
    input  i_err_clear,
    output o_data_byte,
    output o_data_valid,
    output o_busy,
    output o_frame_error,
    output o_overrun
  );

  modport master (
    output i_data_read,
    output i_err_clear,
    input  o_data_byte,
    input  o_data_valid,
    input  o_busy,
    input  o_frame_error,
    input  o_overrun
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style async serial receiver, LSB first, oversampled on clk, with a one-entry
// holding register, valid/read handshake and sticky framing/overrun flags.
module uart_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      i_rx,
  uart_rx_if.slave  bus
);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [BIDX_W-1:0] BIT_LAST = BIDX_W'(DATA_BITS - 1);
  localparam logic [BIDX_W-1:0] BIT_ONE  = BIDX_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIDX_W-1:0]    r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_busy;
  logic                 r_frame_error;
  logic                 r_overrun;
  logic                 w_rx_s;

  assign w_rx_s = r_sync2;

  // Two-flop synchronizer, preset to the idle-high line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
    end
  end

  // Receive FSM, holding register and sticky error flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_clk_cnt     <= '0;
      r_bit_idx     <= '0;
      r_shreg       <= '0;
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_error <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      // Clears first; a commit or error later in this block overrides them.
      if (bus.i_data_read && r_valid) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
      if (bus.i_err_clear) begin
        r_frame_error <= 1'b0;
        r_overrun     <= 1'b0;
      end else begin
        r_frame_error <= r_frame_error;
        r_overrun     <= r_overrun;
      end

      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end
        S_START: begin
          if (r_clk_cnt == CNT_MID) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
          end
        end
        S_DATA: begin
          if (r_clk_cnt == CNT_MAX) begin
            r_clk_cnt <= '0;
            r_shreg   <= DATA_BITS'({w_rx_s, r_shreg} >> 1);
            r_bit_idx <= r_bit_idx + BIT_ONE;
            if (r_bit_idx == BIT_LAST) begin
              r_state <= S_STOP;
            end else begin
              r_state <= S_DATA;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
          end
        end
        S_STOP: begin
          if (r_clk_cnt == CNT_MAX) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_data  <= r_shreg;
              r_valid <= 1'b1;
              if (r_valid && !bus.i_data_read) begin
                r_overrun <= 1'b1;
              end else begin
                r_overrun <= r_overrun && !bus.i_err_clear;
              end
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_frame_error <= 1'b1;
              r_state       <= S_BREAK;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_ONE;
          end
        end
        S_BREAK: begin
          // Wait out a held-low line so a long break reports only one error.
          if (w_rx_s) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_state <= S_BREAK;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_clk_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.o_data_byte   = r_data;
  assign bus.o_data_valid  = r_valid;
  assign bus.o_busy        = r_busy;
  assign bus.o_frame_error = r_frame_error;
  assign bus.o_overrun     = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clk/bit, 8 data bits; inputs change and outputs are sampled on negedge.
module tb_uart_rx;
  localparam int CPB = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic i_rx    = 1'b1;
  int   n_vec   = 0;
  int   n_err   = 0;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_rx    (i_rx),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Called right after a negedge; returns on a negedge with the line left at stop_val.
  task automatic drive_frame(input logic [7:0] data, input int stop_cycles, input logic stop_val);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      i_rx = data[b];
      repeat (CPB) @(negedge clk);
    end
    i_rx = stop_val;
    repeat (stop_cycles) @(negedge clk);
  endtask

  // Frame with a one-cycle read (sel=1) or clear (sel=2) pulse aligned to the commit edge.
  task automatic drive_frame_pulse(input logic [7:0] data, input int sel);
    fork
      drive_frame(data, CPB, 1'b1);
      begin
        repeat (154) @(negedge clk);
        if (sel == 1) bus.i_data_read = 1'b1;
        else          bus.i_err_clear = 1'b1;
        @(negedge clk);
        bus.i_data_read = 1'b0;
        bus.i_err_clear = 1'b0;
      end
    join
  endtask

  task automatic pulse_read();
    bus.i_data_read = 1'b1;
    @(negedge clk);
    bus.i_data_read = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.o_data_byte, bus.o_data_valid, bus.o_busy, bus.o_frame_error, bus.o_overrun} !== 12'h000) begin
      $display("FAIL reset_outputs: got %h expected 000",
               {bus.o_data_byte, bus.o_data_valid, bus.o_busy, bus.o_frame_error, bus.o_overrun});
      n_err++;
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    int first_k = -1;
    fork
      drive_frame(8'hA5, CPB, 1'b1);
      begin
        for (int k = 1; k <= 200; k++) begin
          @(negedge clk);
          if (bus.o_data_valid && first_k < 0) first_k = k;
        end
      end
    join
    n_vec++;
    if (first_k !== 155) begin
      $display("FAIL basic_latency: got %0d expected 155", first_k); n_err++;
    end
    n_vec++;
    if (bus.o_data_byte !== 8'hA5) begin
      $display("FAIL basic_data: got %h expected a5", bus.o_data_byte); n_err++;
    end
    n_vec++;
    if ({bus.o_busy, bus.o_frame_error, bus.o_overrun} !== 3'b000) begin
      $display("FAIL basic_flags: got %b expected 000", {bus.o_busy, bus.o_frame_error, bus.o_overrun}); n_err++;
    end
    repeat (20) @(negedge clk);
    n_vec++;
    if (bus.o_data_valid !== 1'b1) begin
      $display("FAIL basic_valid_hold: got %b expected 1", bus.o_data_valid); n_err++;
    end
    pulse_read();
    n_vec++;
    if (bus.o_data_valid !== 1'b0) begin
      $display("FAIL basic_read_clear: got %b expected 0", bus.o_data_valid); n_err++;
    end
    pulse_read();
    n_vec++;
    if ({bus.o_data_valid, bus.o_overrun} !== 2'b00) begin
      $display("FAIL basic_empty_read: got %b expected 00", {bus.o_data_valid, bus.o_overrun}); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got [2];
    int  n_got = 0;
    int  gap = 0;
    int  max_gap = 0;
    bit  seen_busy = 1'b0;
    got[0] = 8'hxx;
    got[1] = 8'hxx;
    fork
      begin
        drive_frame(8'h00, 9, 1'b1);
        drive_frame(8'hFF, CPB, 1'b1);
      end
      begin
        for (int k = 1; k <= 340; k++) begin
          @(negedge clk);
          if (bus.i_data_read) begin
            bus.i_data_read = 1'b0;
          end else if (bus.o_data_valid) begin
            if (n_got < 2) got[n_got] = bus.o_data_byte;
            n_got++;
            bus.i_data_read = 1'b1;
          end
          if (bus.o_busy) begin
            if (seen_busy && gap > max_gap) max_gap = gap;
            seen_busy = 1'b1;
            gap = 0;
          end else if (seen_busy) begin
            gap++;
          end
        end
      end
    join
    bus.i_data_read = 1'b0;
    n_vec++;
    if (n_got !== 2) begin
      $display("FAIL b2b_count: got %0d expected 2", n_got); n_err++;
    end
    n_vec++;
    if ({got[0], got[1]} !== 16'h00FF) begin
      $display("FAIL b2b_data: got %h%h expected 00ff", got[0], got[1]); n_err++;
    end
    n_vec++;
    if (max_gap !== 1) begin
      $display("FAIL b2b_busy_gap: got %0d expected 1", max_gap); n_err++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    i_rx = 1'b0;
    repeat (3) @(negedge clk);
    i_rx = 1'b1;
    n_vec++;
    if (bus.o_busy !== 1'b1) begin
      $display("FAIL glitch_busy: got %b expected 1", bus.o_busy); n_err++;
    end
    repeat (9) @(negedge clk);
    n_vec++;
    if ({bus.o_busy, bus.o_data_valid, bus.o_frame_error, bus.o_overrun} !== 4'b0000) begin
      $display("FAIL glitch_idle: got %b expected 0000",
               {bus.o_busy, bus.o_data_valid, bus.o_frame_error, bus.o_overrun}); n_err++;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_frame_error();
    drive_frame(8'h3C, 200, 1'b0);
    n_vec++;
    if ({bus.o_frame_error, bus.o_data_valid, bus.o_busy} !== 3'b101) begin
      $display("FAIL ferr_set: got %b expected 101", {bus.o_frame_error, bus.o_data_valid, bus.o_busy}); n_err++;
    end
    bus.i_err_clear = 1'b1;
    @(negedge clk);
    bus.i_err_clear = 1'b0;
    n_vec++;
    if (bus.o_frame_error !== 1'b0) begin
      $display("FAIL ferr_clear: got %b expected 0", bus.o_frame_error); n_err++;
    end
    repeat (440) @(negedge clk);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if ({bus.o_frame_error, bus.o_data_valid, bus.o_busy} !== 3'b000) begin
      $display("FAIL ferr_no_retrigger: got %b expected 000", {bus.o_frame_error, bus.o_data_valid, bus.o_busy}); n_err++;
    end
  endtask

  task automatic test_overrun();
    drive_frame(8'h11, CPB, 1'b1);
    n_vec++;
    if ({bus.o_data_byte, bus.o_data_valid, bus.o_overrun} !== 10'b0001_0001_1_0) begin
      $display("FAIL ovr_first: got %b expected 0001000110", {bus.o_data_byte, bus.o_data_valid, bus.o_overrun}); n_err++;
    end
    // Clear pulse coincides with the overrun commit; the set must win.
    drive_frame_pulse(8'h22, 2);
    n_vec++;
    if ({bus.o_data_byte, bus.o_data_valid, bus.o_overrun} !== 10'b0010_0010_1_1) begin
      $display("FAIL ovr_set: got %b expected 0010001011", {bus.o_data_byte, bus.o_data_valid, bus.o_overrun}); n_err++;
    end
    bus.i_err_clear = 1'b1;
    @(negedge clk);
    bus.i_err_clear = 1'b0;
    n_vec++;
    if (bus.o_overrun !== 1'b0) begin
      $display("FAIL ovr_clear: got %b expected 0", bus.o_overrun); n_err++;
    end
    pulse_read();
    drive_frame(8'h11, CPB, 1'b1);
    drive_frame_pulse(8'h22, 1);
    n_vec++;
    if ({bus.o_data_byte, bus.o_data_valid, bus.o_overrun} !== 10'b0010_0010_1_0) begin
      $display("FAIL ovr_read_commit: got %b expected 0010001010", {bus.o_data_byte, bus.o_data_valid, bus.o_overrun}); n_err++;
    end
    pulse_read();
    n_vec++;
    if (bus.o_data_valid !== 1'b0) begin
      $display("FAIL ovr_final_read: got %b expected 0", bus.o_data_valid); n_err++;
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] pat;
    pat = 8'h55;
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int b = 0; b < 3; b++) begin
      i_rx = pat[b];
      repeat (CPB) @(negedge clk);
    end
    n_vec++;
    if (bus.o_busy !== 1'b1) begin
      $display("FAIL rst_mid_busy: got %b expected 1", bus.o_busy); n_err++;
    end
    reset_n = 1'b0;
    i_rx    = 1'b1;
    #1;
    n_vec++;
    if ({bus.o_data_byte, bus.o_data_valid, bus.o_busy, bus.o_frame_error, bus.o_overrun} !== 12'h000) begin
      $display("FAIL rst_mid_async: got %h expected 000",
               {bus.o_data_byte, bus.o_data_valid, bus.o_busy, bus.o_frame_error, bus.o_overrun}); n_err++;
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if ({bus.o_data_valid, bus.o_busy} !== 2'b00) begin
      $display("FAIL rst_mid_no_partial: got %b expected 00", {bus.o_data_valid, bus.o_busy}); n_err++;
    end
    drive_frame(8'h0F, CPB, 1'b1);
    n_vec++;
    if ({bus.o_data_byte, bus.o_data_valid, bus.o_frame_error, bus.o_overrun} !== 11'b0000_1111_1_0_0) begin
      $display("FAIL rst_mid_next: got %b expected 00001111100",
               {bus.o_data_byte, bus.o_data_valid, bus.o_frame_error, bus.o_overrun}); n_err++;
    end
    pulse_read();
  endtask

  initial begin
    bus.i_data_read = 1'b0;
    bus.i_err_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
